gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin arbiter that shares one GcdUnit among `NUM_REQ` client ports. Each client uses the same val/rdy request/response protocol as GcdUnit. The arbiter keeps exactly one transaction outstanding at a time and returns each result only to the client that issued it. It sits between the client blocks and the GcdUnit instance; the GcdUnit connects directly to the `gcd_*` ports.

## Interface
- `NUM_REQ`, default 4: number of client ports, range 2–16.
- `MSG_W`, default 32: request message width, i.e. operands {a, b}, passed through unmodified.
- `RESP_W`, default 16: response width (GCD result).
- `ID_W`, derived as `$clog2(NUM_REQ)`: client index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cli_req_val`  in  NUM_REQ  per-client request valid.
- `cli_req_rdy`  out  NUM_REQ  per-client request accept; one-hot or zero.
- `cli_req_msg`  in  NUM_REQ*MSG_W  client i occupies bits [i*MSG_W +: MSG_W].
- `cli_resp_val`  out  NUM_REQ  per-client response valid; one-hot or zero.
- `cli_resp_rdy`  in  NUM_REQ  per-client response ready.
- `cli_resp_msg`  out  RESP_W  shared response data; meaningful only where `cli_resp_val` is set.
- `gcd_req_val`  out  1  to GcdUnit `req_val`.
- `gcd_req_rdy`  in  1  from GcdUnit `req_rdy`.
- `gcd_req_msg`  out  MSG_W  to GcdUnit `req_msg`.
- `gcd_resp_val`  in  1  from GcdUnit `resp_val`.
- `gcd_resp_rdy`  out  1  to GcdUnit `resp_rdy`.
- `gcd_resp_msg`  in  RESP_W  from GcdUnit `resp_msg`.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  ID_W  index of the current or last granted client.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DELIVER → IDLE.
- **IDLE**
  - The winner is the first set bit of `cli_req_val`, searched upward from `last_grant+1` modulo `NUM_REQ`.
  - `cli_req_rdy[winner]` is asserted combinationally in the same cycle.
  - On that handshake: capture the winner's message into `req_q`, `grant_id <= winner`, go to ISSUE.
  - No valid requests: stay in IDLE with all `rdy` bits at 0.
- **ISSUE**
  - `gcd_req_val = 1` and `gcd_req_msg = req_q`.
  - When `gcd_req_rdy` is high, go to WAIT.
- **WAIT**
  - `gcd_resp_rdy = 1`.
  - When `gcd_resp_val` is high, capture `gcd_resp_msg` into `resp_q` and go to DELIVER.
- **DELIVER**
  - `cli_resp_val[grant_id] = 1` and `cli_resp_msg = resp_q`.
  - When `cli_resp_rdy[grant_id]` is high: `last_grant <= grant_id`, go to IDLE.
  - The response is held stable until accepted. No new request is accepted in this state.
- `gcd_resp_rdy` is 0 outside WAIT. `gcd_req_val` is 0 outside ISSUE.
- Client requests are not latched or queued. A client that drops `cli_req_val` before being granted simply loses its turn.
- Fairness: a continuously requesting client waits at most `NUM_REQ-1` transactions.

## Timing
- Reset values, applied asynchronously on `reset_n` low:
  - state = IDLE, `last_grant = NUM_REQ-1` (so client 0 wins first), `grant_id = 0`.
  - `req_q = 0`, `resp_q = 0`.
  - All `val`/`rdy` outputs 0, `busy = 0`.
- Minimum latency, with `gcd_req_rdy` high and the GcdUnit taking G cycles:
  - Client handshake at cycle 0; `gcd_req_val` high at cycle 1.
  - `cli_resp_val` high one cycle after the `gcd_resp_val` handshake.
- Back-to-back: the next client handshake can occur at the earliest in the cycle after the DELIVER handshake.
- Simultaneous requests in IDLE: exactly one grant, per round-robin order.
- `gcd_resp_val` arriving in ISSUE is not acknowledged (`gcd_resp_rdy = 0`).
- Reset mid-transaction: the in-flight transaction is discarded and no response is emitted afterwards.
  - The GcdUnit reset must be driven from the same reset source, so its internal state is cleared too.
  - The integration drives GcdUnit's active-high `reset` with `~reset_n`.
- `NUM_REQ` not a power of two: round-robin wraps at `NUM_REQ-1`, never at 2^ID_W−1.

## Structure
- Package `gcd_pkg` holds:
  - the `gcd_arb_state_e` enum (IDLE, ISSUE, WAIT, DELIVER);
  - `GCD_MSG_W = 32` and `GCD_RESP_W = 16`.
- Sub-module `gcd_rr_pick`: a combinational round-robin priority picker.
  - Inputs: `req` [NUM_REQ] and `last` [ID_W].
  - Outputs: `any`, `idx` [ID_W], `onehot` [NUM_REQ].
  - Implemented with the double-width masked priority search.
- All registers live in `gcd_arbiter`.

## Test plan
- Single client: client 1 sends `0x0030_0012` (48, 18) → `gcd_req_msg = 0x0030_0012` one cycle after grant; `cli_resp_val = 0b0010` with `cli_resp_msg = 0x0006`; `grant_id = 1`.
- All four clients request together with distinct operand pairs (48,18), (35,14), (17,5), (100,75) → grants in order 0, 1, 2, 3; responses 6, 7, 1, 25, each routed only to its own client.
- Client 2 holds `cli_resp_rdy = 0` for 5 cycles in DELIVER → response stays stable; `cli_req_rdy` stays 0 for all clients; `gcd_resp_rdy` stays 0.
- Wrap-around with `NUM_REQ = 3`: clients 0 and 2 request continuously → grants alternate 0, 2, 0, 2; never an index ≥ 3.
- Assert `reset_n` low in WAIT while the GcdUnit is computing → `busy = 0` and all `val` outputs 0 immediately, no stale response afterwards; a fresh request from client 0 completes correctly.
- Client 3 drops `cli_req_val` in a cycle where client 1 wins → client 3 gets no `rdy` and its message is never issued.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter slice.
//   gcd_arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT, DELIVER)
//   GCD_MSG_W       : GcdUnit request width, operands {a[31:16], b[15:0]}
//   GCD_RESP_W      : GcdUnit response width
package gcd_pkg;

    localparam int GCD_MSG_W  = 32;
    localparam int GCD_RESP_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } gcd_arb_state_e;

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin priority picker.
//   req    [NUM_REQ] : request vector
//   last   [ID_W]    : index granted most recently; search starts just above it
//   any              : at least one request present
//   idx    [ID_W]    : winning index
//   onehot [NUM_REQ] : winning index as a one-hot vector (zero when !any)
module gcd_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] masked_s;
    int                   start_s;

    // Search start is one past the last grant, wrapping at NUM_REQ-1 (not at 2^ID_W-1).
    always_comb begin
        if (int'(last) >= NUM_REQ - 32'sd1) begin
            start_s = 32'sd0;
        end else begin
            start_s = int'(last) + 32'sd1;
        end
    end

    // Doubling the vector and masking positions below the start lets a single
    // upward search cover the wrap-around.
    always_comb begin
        dbl_s    = {req, req};
        masked_s = '0;
        for (int i = 0; i < 2*NUM_REQ; i++) begin
            masked_s[i] = dbl_s[i] & (i >= start_s);
        end
    end

    // Descending scan: the lowest set bit of the masked vector is written last and wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            any = any | masked_s[i];
            idx = masked_s[i] ? ID_W'((i >= NUM_REQ) ? (i - NUM_REQ) : i) : idx;
        end
        if (any) begin
            onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GcdUnit among NUM_REQ clients, one
// transaction outstanding at a time.
//   clk, reset_n          : clock, asynchronous active-low reset
//   cli_req_val/rdy/msg   : per-client request channel (msg i at [i*MSG_W +: MSG_W])
//   cli_resp_val/rdy      : per-client response channel, cli_resp_msg shared
//   gcd_req_*/gcd_resp_*  : connect straight to the GcdUnit
//   busy                  : high whenever the FSM is not IDLE
//   grant_id              : current or most recently granted client
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = GCD_MSG_W,
    parameter int RESP_W  = GCD_RESP_W,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       cli_req_val,
    output logic [NUM_REQ-1:0]       cli_req_rdy,
    input  logic [NUM_REQ*MSG_W-1:0] cli_req_msg,
    output logic [NUM_REQ-1:0]       cli_resp_val,
    input  logic [NUM_REQ-1:0]       cli_resp_rdy,
    output logic [RESP_W-1:0]        cli_resp_msg,
    output logic                     gcd_req_val,
    input  logic                     gcd_req_rdy,
    output logic [MSG_W-1:0]         gcd_req_msg,
    input  logic                     gcd_resp_val,
    output logic                     gcd_resp_rdy,
    input  logic [RESP_W-1:0]        gcd_resp_msg,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);

    gcd_arb_state_e       state_r;
    logic [ID_W-1:0]      last_grant_r;
    logic [ID_W-1:0]      grant_id_r;
    logic [MSG_W-1:0]     req_q_r;
    logic [RESP_W-1:0]    resp_q_r;
    logic                 gcd_req_val_r;
    logic                 gcd_resp_rdy_r;
    logic [NUM_REQ-1:0]   cli_resp_val_r;
    logic                 busy_r;

    logic                 pick_any_s;
    logic [ID_W-1:0]      pick_idx_s;
    logic [NUM_REQ-1:0]   pick_onehot_s;

    gcd_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (cli_req_val),
        .last   (last_grant_r),
        .any    (pick_any_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Accept goes to the winner in the same cycle, and only while IDLE.
    always_comb begin
        if (state_r == IDLE) begin
            cli_req_rdy = pick_onehot_s;
        end else begin
            cli_req_rdy = '0;
        end
    end

    // Arbiter FSM; handshake outputs are registered alongside the state so
    // they always agree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            last_grant_r   <= ID_W'(NUM_REQ - 1);
            grant_id_r     <= '0;
            req_q_r        <= '0;
            resp_q_r       <= '0;
            gcd_req_val_r  <= 1'b0;
            gcd_resp_rdy_r <= 1'b0;
            cli_resp_val_r <= '0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A winner always has its val high, so any == handshake.
                    if (pick_any_s) begin
                        req_q_r       <= cli_req_msg[int'(pick_idx_s)*MSG_W +: MSG_W];
                        grant_id_r    <= pick_idx_s;
                        gcd_req_val_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gcd_req_rdy) begin
                        gcd_req_val_r  <= 1'b0;
                        gcd_resp_rdy_r <= 1'b1;
                        state_r        <= WAIT;
                    end
                end
                WAIT: begin
                    if (gcd_resp_val) begin
                        resp_q_r       <= gcd_resp_msg;
                        gcd_resp_rdy_r <= 1'b0;
                        cli_resp_val_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
                        state_r        <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (cli_resp_rdy[grant_id_r]) begin
                        last_grant_r   <= grant_id_r;
                        cli_resp_val_r <= '0;
                        busy_r         <= 1'b0;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    gcd_req_val_r  <= 1'b0;
                    gcd_resp_rdy_r <= 1'b0;
                    cli_resp_val_r <= '0;
                    busy_r         <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

    assign cli_resp_val = cli_resp_val_r;
    assign cli_resp_msg = resp_q_r;
    assign gcd_req_val  = gcd_req_val_r;
    assign gcd_req_msg  = req_q_r;
    assign gcd_resp_rdy = gcd_resp_rdy_r;
    assign busy         = busy_r;
    assign grant_id     = grant_id_r;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: a behavioural GcdUnit, queue-driven
// clients, a round-robin reference model, and a second 3-client instance
// for wrap-around.
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int MW = 32;
    localparam int RW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [N-1:0]    cli_req_val, cli_req_rdy, cli_resp_val, cli_resp_rdy;
    logic [N*MW-1:0] cli_req_msg;
    logic [RW-1:0]   cli_resp_msg;
    logic            gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy;
    logic [MW-1:0]   gcd_req_msg;
    logic [RW-1:0]   gcd_resp_msg;
    logic            busy;
    logic [1:0]      grant_id;

    gcd_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .cli_req_val(cli_req_val), .cli_req_rdy(cli_req_rdy), .cli_req_msg(cli_req_msg),
        .cli_resp_val(cli_resp_val), .cli_resp_rdy(cli_resp_rdy), .cli_resp_msg(cli_resp_msg),
        .gcd_req_val(gcd_req_val), .gcd_req_rdy(gcd_req_rdy), .gcd_req_msg(gcd_req_msg),
        .gcd_resp_val(gcd_resp_val), .gcd_resp_rdy(gcd_resp_rdy), .gcd_resp_msg(gcd_resp_msg),
        .busy(busy), .grant_id(grant_id)
    );

    // Second instance: 3 clients, always-ready GcdUnit stub with resp_val stuck high.
    logic [2:0]    cli_req_val3, cli_req_rdy3, cli_resp_val3, cli_resp_rdy3;
    logic [3*MW-1:0] cli_req_msg3;
    logic [RW-1:0] cli_resp_msg3, gcd_resp_msg3;
    logic          gcd_req_val3, gcd_req_rdy3, gcd_resp_val3, gcd_resp_rdy3, busy3;
    logic [MW-1:0] gcd_req_msg3;
    logic [1:0]    grant_id3;

    gcd_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .cli_req_val(cli_req_val3), .cli_req_rdy(cli_req_rdy3), .cli_req_msg(cli_req_msg3),
        .cli_resp_val(cli_resp_val3), .cli_resp_rdy(cli_resp_rdy3), .cli_resp_msg(cli_resp_msg3),
        .gcd_req_val(gcd_req_val3), .gcd_req_rdy(gcd_req_rdy3), .gcd_req_msg(gcd_req_msg3),
        .gcd_resp_val(gcd_resp_val3), .gcd_resp_rdy(gcd_resp_rdy3), .gcd_resp_msg(gcd_resp_msg3),
        .busy(busy3), .grant_id(grant_id3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return 16'(x);
    endfunction

    // Round-robin rule: first requester at or after last+1, modulo N.
    function automatic int rr_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Scoreboard and client state.
    logic [MW-1:0] cli_q [N][$];
    logic [RW-1:0] exp_q [N][$];
    int            grant_log[$];
    int            model_last = N - 1;
    logic [N-1:0]  hs_seen  = '0;
    logic [N-1:0]  hold_rdy = '0;
    logic          ovr = 1'b0;
    logic [MW-1:0] forbidden_msg = 32'hFFFF_FFFF;

    // Behavioural GcdUnit: takes 2..6 cycles, holds resp until accepted.
    logic gm_busy;
    int   gm_cnt;
    assign gcd_req_rdy = !gm_busy;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gm_busy <= 1'b0; gm_cnt <= 0; gcd_resp_val <= 1'b0; gcd_resp_msg <= '0;
        end else if (!gm_busy) begin
            if (gcd_req_val) begin
                gm_busy      <= 1'b1;
                gm_cnt       <= $urandom_range(2, 6);
                gcd_resp_msg <= ref_gcd(gcd_req_msg[31:16], gcd_req_msg[15:0]);
            end
        end else if (!gcd_resp_val) begin
            if (gm_cnt <= 1) gcd_resp_val <= 1'b1;
            else gm_cnt <= gm_cnt - 1;
        end else if (gcd_resp_rdy) begin
            gcd_resp_val <= 1'b0;
            gm_busy      <= 1'b0;
        end
    end

    // Client driver: present queue heads, retire on handshake, random resp_rdy.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs_seen[i] && cli_q[i].size() > 0) void'(cli_q[i].pop_front());
                if (!ovr) begin
                    if (cli_q[i].size() > 0) begin
                        cli_req_val[i] = 1'b1;
                        cli_req_msg[i*MW +: MW] = cli_q[i][0];
                    end else begin
                        cli_req_val[i] = 1'b0;
                    end
                end
                cli_resp_rdy[i] = hold_rdy[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
            hs_seen = '0;
        end
    end

    // Monitor: arbitration against the model, response routing against the scoreboard.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int w, c;
        if (reset_n) begin
            exp_rdy = '0;
            if (!busy) begin
                w = rr_winner(cli_req_val, model_last);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            check("req_rdy", cli_req_rdy, exp_rdy);
            for (int i = 0; i < N; i++) if (cli_req_val[i] && cli_req_rdy[i]) grant_log.push_back(i);
            hs_seen = hs_seen | (cli_req_val & cli_req_rdy);
            if (gcd_req_val && gcd_req_rdy) check("dropped_msg_issued", gcd_req_msg == forbidden_msg, 0);
            if (cli_resp_val != '0) begin
                check("resp_onehot", $onehot(cli_resp_val), 1);
                c = 0;
                for (int i = 0; i < N; i++) if (cli_resp_val[i]) c = i;
                check("resp_grant_id", grant_id, c);
                if (cli_resp_rdy[c]) begin
                    if (exp_q[c].size() == 0) begin
                        check("stale_resp", 1, 0);
                    end else begin
                        check("resp_msg", cli_resp_msg, exp_q[c].pop_front());
                    end
                    model_last = c;
                end
            end
        end
    end

    // Wrap-around monitor for the 3-client instance: clients 0 and 2 alternate.
    int exp3 = 0;
    int n3   = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            check("wrap_gid_range", grant_id3 < 2'd3, 1);
            if (gcd_req_val3) check("spurious_resp_ack", gcd_resp_rdy3, 0);
            if (cli_req_rdy3 != '0 && n3 < 8) begin
                check("wrap_grant", cli_req_rdy3, 3'b001 << exp3);
                exp3 = (exp3 == 0) ? 2 : 0;
                n3++;
            end
        end
    end

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (cli_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while (k < max_cyc && !(all_empty() && !busy)) begin
            @(negedge clk); k++;
        end
        check("drain_timeout", k < max_cyc, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_req(input int c, input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
        cli_q[c].push_back({a, b});
        exp_q[c].push_back(r);
    endtask

    initial begin
        logic [15:0] a, b, held;
        int k;
        reset_n = 1'b0;
        cli_req_val = '0; cli_req_msg = '0; cli_resp_rdy = '0;
        cli_req_val3 = 3'b101; cli_req_msg3 = '0; cli_resp_rdy3 = 3'b111;
        gcd_req_rdy3 = 1'b1; gcd_resp_val3 = 1'b1; gcd_resp_msg3 = 16'h0000;

        // Reset values.
        #12;
        check("rst_busy", busy, 0);
        check("rst_resp_val", cli_resp_val, 0);
        check("rst_gcd_req_val", gcd_req_val, 0);
        check("rst_gcd_resp_rdy", gcd_resp_rdy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_req_q", gcd_req_msg, 0);
        check("rst_resp_q", cli_resp_msg, 0);
        @(negedge clk); reset_n = 1'b1;

        // All four request at once: grants 0,1,2,3 (client 0 first out of reset).
        grant_log.delete();
        push_req(0, 16'd48, 16'd18, 16'd6);
        push_req(1, 16'd35, 16'd14, 16'd7);
        push_req(2, 16'd17, 16'd5, 16'd1);
        push_req(3, 16'd100, 16'd75, 16'd25);
        wait_idle(500);
        check("all4_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("all4_order", grant_log[i], i);

        // Single client 1: issue one cycle after the grant.
        ovr = 1'b1;
        exp_q[1].push_back(16'h0006);
        @(posedge clk); #1;
        cli_req_val = 4'b0010; cli_req_msg[1*MW +: MW] = 32'h0030_0012;
        @(negedge clk); check("single_rdy", cli_req_rdy, 4'b0010);
        @(posedge clk); #1; cli_req_val = '0;
        @(negedge clk);
        check("single_issue_val", gcd_req_val, 1);
        check("single_issue_msg", gcd_req_msg, 32'h0030_0012);
        check("single_grant_id", grant_id, 1);
        ovr = 1'b0;
        wait_idle(200);

        // Client 0 transaction so client 1 outranks client 3, then client 3 drops.
        push_req(0, 16'd12, 16'd8, 16'd4);
        wait_idle(200);
        ovr = 1'b1;
        forbidden_msg = {16'd99, 16'd33};
        exp_q[1].push_back(16'd5);
        @(posedge clk); #1;
        cli_req_val = 4'b1010;
        cli_req_msg[1*MW +: MW] = {16'd25, 16'd10};
        cli_req_msg[3*MW +: MW] = forbidden_msg;
        @(negedge clk); check("drop_winner", cli_req_rdy, 4'b0010);
        @(posedge clk); #1; cli_req_val = '0;
        ovr = 1'b0;
        wait_idle(200);

        // Client 2 holds its response for 5 cycles while others request.
        hold_rdy = 4'b0100;
        push_req(2, 16'd84, 16'd36, 16'd12);
        k = 0;
        while (k < 50 && !busy) begin @(negedge clk); k++; end
        push_req(0, 16'd9, 16'd6, 16'd3);
        push_req(1, 16'd21, 16'd14, 16'd7);
        push_req(3, 16'd64, 16'd48, 16'd16);
        k = 0;
        while (k < 100 && cli_resp_val != 4'b0100) begin @(negedge clk); k++; end
        check("hold_reach_deliver", k < 100, 1);
        held = cli_resp_msg;
        check("hold_msg", held, 16'd12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_val", cli_resp_val, 4'b0100);
            check("hold_stable", cli_resp_msg, held);
            check("hold_no_req_rdy", cli_req_rdy, 0);
            check("hold_no_gcd_rdy", gcd_resp_rdy, 0);
        end
        hold_rdy = '0;
        wait_idle(500);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom_range(1, 1000));
            b = 16'($urandom_range(1, 1000));
            push_req($urandom_range(0, N-1), a, b, ref_gcd(a, b));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle(5000);

        // Reset in WAIT while the GcdUnit computes: transaction discarded.
        push_req(2, 16'd77, 16'd21, 16'd7);
        k = 0;
        while (k < 50 && !(gcd_resp_rdy && !gcd_resp_val)) begin @(negedge clk); k++; end
        check("reach_wait", k < 50, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_resp_val", cli_resp_val, 0);
        check("midrst_gcd_req_val", gcd_req_val, 0);
        check("midrst_gcd_resp_rdy", gcd_resp_rdy, 0);
        for (int i = 0; i < N; i++) begin cli_q[i].delete(); exp_q[i].delete(); end
        model_last = N - 1;
        exp3 = 0;
        @(negedge clk); #2 reset_n = 1'b1;
        push_req(0, 16'd60, 16'd45, 16'd15);
        wait_idle(200);
        repeat (10) @(negedge clk);

        check("wrap_count", n3, 8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
